// File: rtl/chunked_ripple_adder_if.sv
// Operand/result handshake bundle for the chunked ripple adder.
// master = producer/consumer side, slave = adder side.
interface chunked_ripple_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             c_i;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             c_o;
    logic             ovf;

    modport master (
        output in_valid, x, y, c_i, sub, out_ready,
        input  in_ready, out_valid, s, c_o, ovf
    );

    modport slave (
        input  in_valid, x, y, c_i, sub, out_ready,
        output in_ready, out_valid, s, c_o, ovf
    );
endinterface

// File: rtl/chunked_ripple_adder.sv
// Multi-cycle ripple adder/subtractor, one CHUNK slice per cycle; result NCH cycles after accept.
// Accepts only in IDLE; holds the result in DONE until out_ready, no same-cycle re-accept.
module chunked_ripple_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    chunked_ripple_adder_if.slave bus
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_s;
    logic             r_carry;
    logic             r_c_o;
    logic             r_ovf;
    logic [CW-1:0]    r_cnt;

    logic [CHUNK-1:0] w_xs;
    logic [CHUNK-1:0] w_ys;
    logic [CHUNK:0]   w_sum;
    logic             w_c_msb;
    logic             w_last;
    logic             w_in_ready;
    logic             w_out_valid;

    assign w_xs   = r_x[r_cnt*CHUNK +: CHUNK];
    assign w_ys   = r_y[r_cnt*CHUNK +: CHUNK];
    assign w_sum  = {1'b0, w_xs} + {1'b0, w_ys} + {{CHUNK{1'b0}}, r_carry};
    assign w_last = (r_cnt == LAST);

    // Carry into the slice MSB recovered from its sum bit; works for CHUNK=1 too.
    assign w_c_msb = w_sum[CHUNK-1] ^ w_xs[CHUNK-1] ^ w_ys[CHUNK-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x     <= '0;
            r_y     <= '0;
            r_s     <= '0;
            r_carry <= 1'b0;
            r_c_o   <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_x     <= bus.x;
                        r_y     <= bus.sub ? ~bus.y : bus.y;
                        r_carry <= bus.sub | bus.c_i;
                        r_cnt   <= '0;
                        r_s     <= '0;
                    end
                end
                RUN: begin
                    r_s[r_cnt*CHUNK +: CHUNK] <= w_sum[CHUNK-1:0];
                    r_carry                   <= w_sum[CHUNK];
                    r_cnt                     <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_c_o <= w_sum[CHUNK];
                        r_ovf <= w_c_msb ^ w_sum[CHUNK];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.s         = r_s;
    assign bus.c_o       = r_c_o;
    assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_chunked_ripple_adder.sv
// Drives CHUNK=1, 4 and 16 adders in lockstep with shared stimulus and checks each one.
module tb_chunked_ripple_adder;
    logic        clk = 1'b0;
    logic        rst;
    logic        tb_in_valid;
    logic        tb_c_i;
    logic        tb_sub;
    logic        tb_out_ready;
    logic [15:0] tb_x;
    logic [15:0] tb_y;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    chunked_ripple_adder_if #(.WIDTH(16)) if_c1 ();
    chunked_ripple_adder_if #(.WIDTH(16)) if_c4 ();
    chunked_ripple_adder_if #(.WIDTH(16)) if_c16 ();

    assign if_c1.in_valid  = tb_in_valid;
    assign if_c1.x         = tb_x;
    assign if_c1.y         = tb_y;
    assign if_c1.c_i       = tb_c_i;
    assign if_c1.sub       = tb_sub;
    assign if_c1.out_ready = tb_out_ready;
    assign if_c4.in_valid  = tb_in_valid;
    assign if_c4.x         = tb_x;
    assign if_c4.y         = tb_y;
    assign if_c4.c_i       = tb_c_i;
    assign if_c4.sub       = tb_sub;
    assign if_c4.out_ready = tb_out_ready;
    assign if_c16.in_valid  = tb_in_valid;
    assign if_c16.x         = tb_x;
    assign if_c16.y         = tb_y;
    assign if_c16.c_i       = tb_c_i;
    assign if_c16.sub       = tb_sub;
    assign if_c16.out_ready = tb_out_ready;

    chunked_ripple_adder #(.WIDTH(16), .CHUNK(1))  u_c1  (.clk(clk), .rst(rst), .bus(if_c1));
    chunked_ripple_adder #(.WIDTH(16), .CHUNK(4))  u_c4  (.clk(clk), .rst(rst), .bus(if_c4));
    chunked_ripple_adder #(.WIDTH(16), .CHUNK(16)) u_c16 (.clk(clk), .rst(rst), .bus(if_c16));

    logic        o_in_ready  [3];
    logic        o_out_valid [3];
    logic        o_c_o       [3];
    logic        o_ovf       [3];
    logic [15:0] o_s         [3];

    assign o_in_ready[0]  = if_c1.in_ready;
    assign o_out_valid[0] = if_c1.out_valid;
    assign o_c_o[0]       = if_c1.c_o;
    assign o_ovf[0]       = if_c1.ovf;
    assign o_s[0]         = if_c1.s;
    assign o_in_ready[1]  = if_c4.in_ready;
    assign o_out_valid[1] = if_c4.out_valid;
    assign o_c_o[1]       = if_c4.c_o;
    assign o_ovf[1]       = if_c4.ovf;
    assign o_s[1]         = if_c4.s;
    assign o_in_ready[2]  = if_c16.in_ready;
    assign o_out_valid[2] = if_c16.out_valid;
    assign o_c_o[2]       = if_c16.c_o;
    assign o_ovf[2]       = if_c16.ovf;
    assign o_s[2]         = if_c16.s;

    function automatic int chunk_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 4 : 16);
    endfunction

    function automatic int nch_of(input int i);
        return 16 / chunk_of(i);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: sign-rule overflow on the effective operands.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic ci, input logic sb);
        logic [15:0] yy;
        logic [16:0] r;
        logic        v;
        yy = sb ? ~y : y;
        r  = {1'b0, x} + {1'b0, yy} + {16'd0, (sb ? 1'b1 : ci)};
        v  = (x[15] == yy[15]) && (r[15] != x[15]);
        return {v, r[16], r[15:0]};
    endfunction

    task automatic issue(input string tag, input logic [15:0] x, input logic [15:0] y,
                         input logic ci, input logic sb);
        int lat [3];
        tb_x         = x;
        tb_y         = y;
        tb_c_i       = ci;
        tb_sub       = sb;
        tb_in_valid  = 1'b1;
        tb_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s.in_ready[c%0d]", tag, chunk_of(i)), 32'(o_in_ready[i]), 32'd1);
        end
        step();
        tb_in_valid = 1'b0;
        tb_x        = 16'($urandom);
        tb_y        = 16'($urandom);
        tb_c_i      = ~ci;
        tb_sub      = ~sb;
        for (int i = 0; i < 3; i++) lat[i] = 0;
        for (int c = 1; c <= 20; c++) begin
            step();
            for (int i = 0; i < 3; i++) begin
                if (o_out_valid[i] && lat[i] == 0) lat[i] = c;
            end
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s.latency[c%0d]", tag, chunk_of(i)), 32'(lat[i]), 32'(nch_of(i)));
        end
    endtask

    task automatic check_res(input string tag, input logic [15:0] es, input logic eco,
                             input logic eovf);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s.s[c%0d]", tag, chunk_of(i)),   32'(o_s[i]),   32'(es));
            check($sformatf("%s.c_o[c%0d]", tag, chunk_of(i)), 32'(o_c_o[i]), 32'(eco));
            check($sformatf("%s.ovf[c%0d]", tag, chunk_of(i)), 32'(o_ovf[i]), 32'(eovf));
        end
    endtask

    task automatic retire(input string tag);
        tb_out_ready = 1'b1;
        step();
        tb_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s.ret_out_valid[c%0d]", tag, chunk_of(i)), 32'(o_out_valid[i]), 32'd0);
            check($sformatf("%s.ret_in_ready[c%0d]", tag, chunk_of(i)), 32'(o_in_ready[i]), 32'd1);
        end
    endtask

    task automatic run(input string tag, input logic [15:0] x, input logic [15:0] y,
                       input logic ci, input logic sb, input logic [15:0] es,
                       input logic eco, input logic eovf);
        issue(tag, x, y, ci, sb);
        check_res(tag, es, eco, eovf);
        retire(tag);
    endtask

    initial begin
        logic [17:0] m;
        logic [15:0] rx;
        logic [15:0] ry;
        logic        rci;
        logic        rsb;

        rst          = 1'b1;
        tb_in_valid  = 1'b0;
        tb_x         = 16'h0;
        tb_y         = 16'h0;
        tb_c_i       = 1'b0;
        tb_sub       = 1'b0;
        tb_out_ready = 1'b0;
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst.in_ready[c%0d]", chunk_of(i)),  32'(o_in_ready[i]),  32'd1);
            check($sformatf("rst.out_valid[c%0d]", chunk_of(i)), 32'(o_out_valid[i]), 32'd0);
            check($sformatf("rst.s[c%0d]", chunk_of(i)),         32'(o_s[i]),         32'd0);
            check($sformatf("rst.c_o[c%0d]", chunk_of(i)),       32'(o_c_o[i]),       32'd0);
            check($sformatf("rst.ovf[c%0d]", chunk_of(i)),       32'(o_ovf[i]),       32'd0);
        end
        rst = 1'b0;
        step();

        run("add_carry8", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        run("add_cin",    16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0);
        run("add_wrap",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run("sub_ovf",    16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Held result under backpressure while the producer keeps poking the inputs.
        issue("bp", 16'hA5A5, 16'h1111, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tb_in_valid = ~k[0];
            tb_x        = 16'($urandom);
            tb_y        = 16'($urandom);
            tb_sub      = k[1];
            step();
            check_res($sformatf("bp%0d", k), 16'hB6B7, 1'b0, 1'b0);
            for (int i = 0; i < 3; i++) begin
                check($sformatf("bp%0d.in_ready[c%0d]", k, chunk_of(i)),  32'(o_in_ready[i]),  32'd0);
                check($sformatf("bp%0d.out_valid[c%0d]", k, chunk_of(i)), 32'(o_out_valid[i]), 32'd1);
            end
        end
        tb_in_valid = 1'b0;
        retire("bp");

        // Abort two slices into the CHUNK=4 operation.
        tb_x        = 16'h1111;
        tb_y        = 16'h2222;
        tb_c_i      = 1'b0;
        tb_sub      = 1'b0;
        tb_in_valid = 1'b1;
        step();
        tb_in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("abort.out_valid[c%0d]", chunk_of(i)), 32'(o_out_valid[i]), 32'd0);
            check($sformatf("abort.in_ready[c%0d]", chunk_of(i)),  32'(o_in_ready[i]),  32'd1);
            check($sformatf("abort.s[c%0d]", chunk_of(i)),         32'(o_s[i]),         32'd0);
        end
        run("post_abort", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);

        for (int n = 0; n < 200; n++) begin
            rx  = 16'($urandom);
            ry  = 16'($urandom);
            rci = 1'($urandom_range(0, 1));
            rsb = 1'($urandom_range(0, 1));
            m   = model(rx, ry, rci, rsb);
            run($sformatf("rnd%0d", n), rx, ry, rci, rsb, m[15:0], m[16], m[17]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
